booth_mul: RTL

BOOTH_MUL -- requirements
Module: booth_mul

---
 rtl/booth_mul.sv | 124 ++++++++++++
 1 files changed

// File: rtl/booth_mul.sv
// Radix-4 Booth sequential multiplier, signed or unsigned operands.
// Latency: WIDTH/2+1 clock edges from accept to out_valid, independent of operand values.
// Backpressure: the result holds in DONE until out_ready; in_ready stays low until the FSM is back in IDLE.
module booth_mul #(
   parameter int WIDTH = 32
) (
   input  logic                 mul_clk,
   input  logic                 resetn,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 mul_signed,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 busy
);

   localparam int ITER = WIDTH / 2 + 1;       // Booth digits == compute cycles
   localparam int CW   = $clog2(ITER + 1);
   localparam int PW   = 2 * WIDTH;           // product width; arithmetic is modulo 2^PW
   localparam int MW   = WIDTH + 3;           // extended multiplier plus the implicit bit -1
   localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [PW-1:0]   r_mcand;    // multiplicand, pre-shifted by 2i for the current digit
   logic [MW-1:0]   r_mplier;   // multiplier; bits [2:0] are the current Booth triplet
   logic [PW-1:0]   r_acc;
   logic [PW-1:0]   r_result;
   logic [PW-1:0]   w_pp;
   logic [PW-1:0]   w_acc_nxt;
   logic            w_accept;
   logic            w_last;
   logic            w_x_ext;
   logic            w_y_ext;

   // Handshake and status outputs; in_ready is also held low while reset is asserted.
   assign in_ready  = resetn & (r_state == S_IDLE) & ~flush;
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign result    = out_valid ? r_result : '0;

   assign w_accept  = in_valid & in_ready;
   assign w_last    = (r_state == S_CALC) && (r_cnt == LAST_CNT);

   // Extension bits: sign for two's-complement operands, zero otherwise.
   assign w_x_ext   = mul_signed & x[WIDTH-1];
   assign w_y_ext   = mul_signed & y[WIDTH-1];

   // State register.
   always_ff @(posedge mul_clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; flush overrides accept and the output handshake.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)  w_state_nxt = S_CALC;
         S_CALC:  if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
      if (flush) begin
         w_state_nxt = S_IDLE;
      end
   end

   // Booth recoding of the current triplet into {0, +-X, +-2X}.
   always_comb begin
      w_pp = '0;
      case (r_mplier[2:0])
         3'b001, 3'b010: w_pp = r_mcand;
         3'b011:         w_pp = {r_mcand[PW-2:0], 1'b0};
         3'b100:         w_pp = -{r_mcand[PW-2:0], 1'b0};
         3'b101, 3'b110: w_pp = -r_mcand;
         default:        w_pp = '0;
      endcase
   end

   assign w_acc_nxt = r_acc + w_pp;

   // Datapath: latch operands at accept, then one digit per CALC edge.
   always_ff @(posedge mul_clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else if (flush) begin
         r_cnt    <= '0;
         r_acc    <= '0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{w_x_ext}}, x};
         r_mplier <= {w_y_ext, w_y_ext, y, 1'b0};
      end else if (r_state == S_CALC) begin
         r_cnt    <= r_cnt + CW'(1);
         r_acc    <= w_acc_nxt;
         r_mcand  <= {r_mcand[PW-3:0], 2'b00};
         r_mplier <= {{2{r_mplier[MW-1]}}, r_mplier[MW-1:2]};
         if (w_last) begin
            r_result <= w_acc_nxt;
         end
      end
   end

endmodule
